// File: rtl/tl_ul_port_arbiter.sv
// Two-requester TL-UL A-channel arbiter with per-source outstanding limits and D-channel routing.
// Define TL_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0 wins).
module tl_ul_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        in0_a_valid,
  output logic        in0_a_ready,
  input  logic [2:0]  in0_a_opcode,
  input  logic [3:0]  in0_a_size,
  input  logic [31:0] in0_a_address,
  input  logic [3:0]  in0_a_mask,
  input  logic [31:0] in0_a_data,

  input  logic        in1_a_valid,
  output logic        in1_a_ready,
  input  logic [2:0]  in1_a_opcode,
  input  logic [3:0]  in1_a_size,
  input  logic [31:0] in1_a_address,
  input  logic [3:0]  in1_a_mask,
  input  logic [31:0] in1_a_data,

  output logic        out_a_valid,
  input  logic        out_a_ready,
  output logic [2:0]  out_a_opcode,
  output logic [3:0]  out_a_size,
  output logic        out_a_source,
  output logic [31:0] out_a_address,
  output logic [3:0]  out_a_mask,
  output logic [31:0] out_a_data,

  input  logic        out_d_valid,
  output logic        out_d_ready,
  input  logic [2:0]  out_d_opcode,
  input  logic [3:0]  out_d_size,
  input  logic        out_d_source,
  input  logic [31:0] out_d_data,

  output logic        in0_d_valid,
  input  logic        in0_d_ready,
  output logic [2:0]  in0_d_opcode,
  output logic [3:0]  in0_d_size,
  output logic [31:0] in0_d_data,

  output logic        in1_d_valid,
  input  logic        in1_d_ready,
  output logic [2:0]  in1_d_opcode,
  output logic [3:0]  in1_d_size,
  output logic [31:0] in1_d_data
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } lock_state_e;

  lock_state_e state_q, state_d;
  logic        lock_src_q;
  logic [2:0]  cnt0_q, cnt1_q, cnt0_d, cnt1_d;
  logic        elig0, elig1, grant, a_fire, d_fire;
  logic        inc0, inc1, dec0, dec1;

`ifdef TL_ARB_ROUND_ROBIN_EN
  logic last_q;

  always_ff @(posedge clock) begin
    if (reset)       last_q <= 1'b1;
    else if (a_fire) last_q <= grant;
  end
`endif

  // Grant selection; a stalled beat keeps the previously chosen source.
  always_comb begin
    elig0 = in0_a_valid && (cnt0_q < MAX_CNT);
    elig1 = in1_a_valid && (cnt1_q < MAX_CNT);
    grant = 1'b0;
    if (state_q == ARB_LOCKED) begin
      grant = lock_src_q;
    end else begin
`ifdef TL_ARB_ROUND_ROBIN_EN
      if (elig0 && elig1) grant = ~last_q;
      else                grant = ~elig0;
`else
      grant = ~elig0;
`endif
    end
  end

  always_comb begin
    out_a_valid   = ~reset & (grant ? elig1 : elig0);
    out_a_source  = grant;
    out_a_opcode  = grant ? in1_a_opcode  : in0_a_opcode;
    out_a_size    = grant ? in1_a_size    : in0_a_size;
    out_a_address = grant ? in1_a_address : in0_a_address;
    out_a_mask    = grant ? in1_a_mask    : in0_a_mask;
    out_a_data    = grant ? in1_a_data    : in0_a_data;
    in0_a_ready   = ~reset & out_a_ready & ~grant & elig0;
    in1_a_ready   = ~reset & out_a_ready &  grant & elig1;
    a_fire        = out_a_valid & out_a_ready;

    state_d = ARB_OPEN;
    if (out_a_valid && !out_a_ready) state_d = ARB_LOCKED;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ARB_OPEN;
      lock_src_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= grant;
    end
  end

  always_comb begin
    out_d_ready  = ~reset & (out_d_source ? in1_d_ready : in0_d_ready);
    in0_d_valid  = ~reset & out_d_valid & ~out_d_source;
    in1_d_valid  = ~reset & out_d_valid &  out_d_source;
    in0_d_opcode = out_d_opcode;
    in0_d_size   = out_d_size;
    in0_d_data   = out_d_data;
    in1_d_opcode = out_d_opcode;
    in1_d_size   = out_d_size;
    in1_d_data   = out_d_data;
    d_fire       = out_d_valid & out_d_ready;
  end

  // Decrement is suppressed at zero so a stray response cannot wrap the count.
  always_comb begin
    inc0 = a_fire & ~grant;
    inc1 = a_fire &  grant;
    dec0 = d_fire & ~out_d_source & (cnt0_q != '0);
    dec1 = d_fire &  out_d_source & (cnt1_q != '0);
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (inc0 && !dec0)      cnt0_d = cnt0_q + 3'd1;
    else if (dec0 && !inc0) cnt0_d = cnt0_q - 3'd1;
    if (inc1 && !dec1)      cnt1_d = cnt1_q + 3'd1;
    else if (dec1 && !inc1) cnt1_d = cnt1_q - 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_tl_ul_port_arbiter.sv
// Directed bench for tl_ul_port_arbiter (MAX_OUTSTANDING=2); expectations follow TL_ARB_ROUND_ROBIN_EN.
module tb_tl_ul_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        in0_a_valid, in0_a_ready, in1_a_valid, in1_a_ready;
  logic [2:0]  in0_a_opcode, in1_a_opcode, out_a_opcode;
  logic [3:0]  in0_a_size, in1_a_size, out_a_size;
  logic [31:0] in0_a_address, in1_a_address, out_a_address;
  logic [3:0]  in0_a_mask, in1_a_mask, out_a_mask;
  logic [31:0] in0_a_data, in1_a_data, out_a_data;
  logic        out_a_valid, out_a_ready, out_a_source;
  logic        out_d_valid, out_d_ready, out_d_source;
  logic [2:0]  out_d_opcode, in0_d_opcode, in1_d_opcode;
  logic [3:0]  out_d_size, in0_d_size, in1_d_size;
  logic [31:0] out_d_data, in0_d_data, in1_d_data;
  logic        in0_d_valid, in0_d_ready, in1_d_valid, in1_d_ready;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

`ifdef TL_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] ADDR0 = 32'h1000_0040;
  localparam logic [31:0] ADDR1 = 32'h2000_0080;

  tl_ul_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
    .in0_a_size(in0_a_size), .in0_a_address(in0_a_address), .in0_a_mask(in0_a_mask),
    .in0_a_data(in0_a_data),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
    .in1_a_size(in1_a_size), .in1_a_address(in1_a_address), .in1_a_mask(in1_a_mask),
    .in1_a_data(in1_a_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_size(out_a_size), .out_a_source(out_a_source), .out_a_address(out_a_address),
    .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
    .in0_d_size(in0_d_size), .in0_d_data(in0_d_data),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
    .in1_d_size(in1_d_size), .in1_d_data(in1_d_data)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic a0v, input logic a1v, input logic ardy, input logic dv,
                       input logic dsrc, input logic d0r, input logic d1r);
    in0_a_valid  = a0v;
    in1_a_valid  = a1v;
    out_a_ready  = ardy;
    out_d_valid  = dv;
    out_d_source = dsrc;
    in0_d_ready  = d0r;
    in1_d_ready  = d1r;
    out_d_data   = out_d_data + 32'h0101_0101;
    #1;
  endtask

  initial begin
    logic prev;
    logic exp_src;
    reset = 1'b1;
    in0_a_opcode = 3'd4; in0_a_size = 4'd2; in0_a_address = ADDR0; in0_a_mask = 4'hF;
    in0_a_data = 32'hA0A0_0000;
    in1_a_opcode = 3'd0; in1_a_size = 4'd1; in1_a_address = ADDR1; in1_a_mask = 4'h3;
    in1_a_data = 32'hB1B1_1111;
    out_d_opcode = 3'd1; out_d_size = 4'd2; out_d_data = 32'h0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Outputs forced low while in reset
    drive(1, 1, 1, 1, 0, 1, 1);
    check_eq("rst_a_valid", 32'(out_a_valid), 0);
    check_eq("rst_in0_a_ready", 32'(in0_a_ready), 0);
    check_eq("rst_in1_a_ready", 32'(in1_a_ready), 0);
    check_eq("rst_in0_d_valid", 32'(in0_d_valid), 0);
    check_eq("rst_out_d_ready", 32'(out_d_ready), 0);
    tick();
    reset = 1'b0;
    drive(0, 0, 1, 0, 0, 1, 1);
    check_eq("idle_a_valid", 32'(out_a_valid), 0);
    tick();

    // Both requesting every cycle; D returns the previous beat to keep counts low
    prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_src = RR ? 1'(i % 2) : 1'b0;
      drive(1, 1, 1, i > 0, prev, 1, 1);
      check_eq("alt_valid", 32'(out_a_valid), 1);
      check_eq("alt_source", 32'(out_a_source), 32'(exp_src));
      check_eq("alt_in0_ready", 32'(in0_a_ready), 32'(!exp_src));
      check_eq("alt_in1_ready", 32'(in1_a_ready), 32'(exp_src));
      check_eq("alt_address", out_a_address, exp_src ? ADDR1 : ADDR0);
      tick();
      prev = exp_src;
    end
    drive(0, 0, 1, 1, prev, 1, 1);
    check_eq("drain_d_ready", 32'(out_d_ready), 1);
    tick();

    // Stalled grant to port 1 must survive port 0 raising valid
    drive(0, 1, 0, 0, 0, 1, 1);
    check_eq("stall_valid", 32'(out_a_valid), 1);
    check_eq("stall_source", 32'(out_a_source), 1);
    check_eq("stall_in1_ready", 32'(in1_a_ready), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 1, 1);
      check_eq("lock_source", 32'(out_a_source), 1);
      check_eq("lock_in0_ready", 32'(in0_a_ready), 0);
      check_eq("lock_data", out_a_data, 32'hB1B1_1111);
      tick();
    end
    drive(1, 1, 1, 0, 0, 1, 1);
    check_eq("unlock_source", 32'(out_a_source), 1);
    check_eq("unlock_in1_ready", 32'(in1_a_ready), 1);
    check_eq("unlock_in0_ready", 32'(in0_a_ready), 0);
    check_eq("unlock_mask", 32'(out_a_mask), 32'h3);
    tick();
    drive(1, 0, 1, 0, 0, 1, 1);
    check_eq("next_source", 32'(out_a_source), 0);
    check_eq("next_in0_ready", 32'(in0_a_ready), 1);
    tick();

    // D routing by source
    drive(0, 0, 0, 1, 1, 0, 1);
    check_eq("d1_in1_valid", 32'(in1_d_valid), 1);
    check_eq("d1_in0_valid", 32'(in0_d_valid), 0);
    check_eq("d1_ready", 32'(out_d_ready), 1);
    check_eq("d1_fanout", in0_d_data, out_d_data);
    tick();
    drive(0, 0, 0, 1, 0, 0, 1);
    check_eq("d0_in0_valid", 32'(in0_d_valid), 1);
    check_eq("d0_in1_valid", 32'(in1_d_valid), 0);
    check_eq("d0_ready_lo", 32'(out_d_ready), 0);
    tick();
    drive(0, 0, 0, 1, 0, 1, 0);
    check_eq("d0_ready_hi", 32'(out_d_ready), 1);
    check_eq("d0_size", 32'(in1_d_size), 32'(out_d_size));
    tick();

    // Outstanding limit on port 0
    drive(1, 0, 1, 0, 0, 1, 1);
    check_eq("lim_first", 32'(in0_a_ready), 1);
    tick();
    drive(1, 0, 1, 0, 0, 1, 1);
    check_eq("lim_second", 32'(in0_a_ready), 1);
    tick();
    drive(1, 0, 1, 0, 0, 1, 1);
    check_eq("lim_third_ready", 32'(in0_a_ready), 0);
    check_eq("lim_third_valid", 32'(out_a_valid), 0);
    tick();
    drive(1, 1, 1, 0, 0, 1, 1);
    check_eq("lim_in1_source", 32'(out_a_source), 1);
    check_eq("lim_in1_ready", 32'(in1_a_ready), 1);
    check_eq("lim_in0_held", 32'(in0_a_ready), 0);
    tick();
    drive(1, 0, 1, 1, 0, 1, 1);
    check_eq("lim_free_same", 32'(out_a_valid), 0);
    tick();
    drive(1, 0, 1, 0, 0, 1, 1);
    check_eq("lim_free_next", 32'(in0_a_ready), 1);
    tick();

    // Simultaneous A and D on port 1 at count 1 keeps count 1
    drive(1, 1, 1, 1, 1, 1, 1);
    check_eq("sim_source", 32'(out_a_source), 1);
    check_eq("sim_in1_ready", 32'(in1_a_ready), 1);
    tick();
    drive(0, 1, 1, 0, 0, 1, 1);
    check_eq("sim_one_slot", 32'(in1_a_ready), 1);
    tick();
    drive(0, 1, 1, 0, 0, 1, 1);
    check_eq("sim_full", 32'(in1_a_ready), 0);
    tick();

    // Counts 2/1 with a stalled lock on port 1, then reset
    drive(0, 0, 0, 1, 1, 1, 1);
    check_eq("pre_d_ready", 32'(out_d_ready), 1);
    tick();
    drive(0, 1, 0, 0, 0, 1, 1);
    check_eq("pre_lock_source", 32'(out_a_source), 1);
    tick();
    reset = 1'b1;
    drive(1, 1, 1, 1, 0, 1, 1);
    check_eq("mid_rst_a_valid", 32'(out_a_valid), 0);
    check_eq("mid_rst_d_valid", 32'(in0_d_valid), 0);
    tick();
    reset = 1'b0;
    drive(1, 1, 0, 0, 0, 1, 1);
    check_eq("post_rst_valid", 32'(out_a_valid), 1);
    check_eq("post_rst_source", 32'(out_a_source), 0);
    tick();
    drive(1, 1, 1, 0, 0, 1, 1);
    check_eq("post_rst_fire", 32'(in0_a_ready), 1);
    tick();
    drive(0, 0, 0, 1, 1, 0, 1);
    check_eq("stray_d_valid", 32'(in1_d_valid), 1);
    check_eq("stray_d_ready", 32'(out_d_ready), 1);
    tick();
    drive(0, 1, 1, 0, 0, 1, 1);
    check_eq("nowrap_first", 32'(in1_a_ready), 1);
    tick();
    drive(0, 1, 1, 0, 0, 1, 1);
    check_eq("nowrap_second", 32'(in1_a_ready), 1);
    tick();
    drive(0, 1, 1, 0, 0, 1, 1);
    check_eq("nowrap_third", 32'(in1_a_ready), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
